// File: rtl/ps2_mouse_device.sv
// rtl/ps2_mouse_device.sv - device-side PS/2 mouse emulator
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   ps2mclk, ps2mdat    open-collector PS/2 clock/data (driven 0 or released)
//   dx, dy, btn         movement deltas and buttons for the next packet
//   pkt_valid/ready     packet handshake from the core
//   reporting           data reporting enabled by the host
//   cmd_byte/strobe     last good host command and its one-cycle update pulse
//   busy                line state machine not idle
module ps2_mouse_device #(
  parameter int HALF_CYC = 860,
  parameter int GAP_CYC  = 2000,
  parameter int RQ_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire        ps2mclk,
  inout  wire        ps2mdat,
  input  logic [8:0] dx,
  input  logic [8:0] dy,
  input  logic [2:0] btn,
  input  logic       pkt_valid,
  output logic       pkt_ready,
  output logic       reporting,
  output logic [7:0] cmd_byte,
  output logic       cmd_strobe,
  output logic       busy
);

  localparam int CNT_MAX = (GAP_CYC > 2 * HALF_CYC) ? GAP_CYC : 2 * HALF_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RQ_AW   = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
  localparam int RQ_CW   = $clog2(RQ_DEPTH + 1);

  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] ACK_END  = CNT_W'(2 * HALF_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_LEN = CNT_W'(HALF_CYC);
  localparam logic [RQ_CW-1:0] RQ_FULL  = RQ_CW'(RQ_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE, ST_GAP, ST_TX_LO, ST_TX_HI, ST_INHIBIT, ST_RX_LO, ST_RX_HI, ST_RX_ACK
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         bit_q, bit_d;
  logic [10:0]        frame_q, frame_d;
  logic [8:0]         rx_q, rx_d;
  logic               tx_src_q, tx_src_d;     // 1: byte in flight came from the packet
  logic [23:0]        pkt_q, pkt_d;           // pending packet bytes, next byte in [7:0]
  logic [1:0]         pkt_cnt_q, pkt_cnt_d;
  logic [7:0]         rq_mem_q [RQ_DEPTH];
  logic [7:0]         rq_mem_d [RQ_DEPTH];
  logic [RQ_AW-1:0]   rq_rd_q, rq_rd_d, rq_wr_q, rq_wr_d;
  logic [RQ_CW-1:0]   rq_cnt_q, rq_cnt_d;
  logic               reporting_q, reporting_d;
  logic [7:0]         cmd_byte_q, cmd_byte_d;
  logic               cmd_strobe_q, cmd_strobe_d;
  logic               arg_q, arg_d;           // next host byte is an F3 argument
  logic               clk_low_q, clk_low_d;
  logic               dat_low_q, dat_low_d;
  logic               clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;

  logic               pend;
  logic [7:0]         tx_byte;
  logic [9:0]         rx_word;
  logic [1:0]         push_n;
  logic [7:0]         push_b [3];

  assign ps2mclk    = clk_low_q ? 1'b0 : 1'bz;
  assign ps2mdat    = dat_low_q ? 1'b0 : 1'bz;
  assign reporting  = reporting_q;
  assign cmd_byte   = cmd_byte_q;
  assign cmd_strobe = cmd_strobe_q;
  assign busy       = (state_q != ST_IDLE);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    frame_d      = frame_q;
    rx_d         = rx_q;
    tx_src_d     = tx_src_q;
    pkt_d        = pkt_q;
    pkt_cnt_d    = pkt_cnt_q;
    rq_mem_d     = rq_mem_q;
    rq_rd_d      = rq_rd_q;
    rq_wr_d      = rq_wr_q;
    rq_cnt_d     = rq_cnt_q;
    reporting_d  = reporting_q;
    cmd_byte_d   = cmd_byte_q;
    cmd_strobe_d = 1'b0;
    arg_d        = arg_q;
    tx_byte      = 8'h00;
    rx_word      = {dat_s2_q, rx_q};
    push_n       = 2'd0;
    push_b[0]    = 8'h00;
    push_b[1]    = 8'h00;
    push_b[2]    = 8'h00;

    pend      = (rq_cnt_q != '0) || (pkt_cnt_q != 2'd0);
    pkt_ready = (state_q == ST_IDLE) && reporting_q && (rq_cnt_q == '0) && (pkt_cnt_q == 2'd0);

    // Overflow bits X/Y are never set; bit 3 is always 1 in a standard packet.
    if (pkt_valid && pkt_ready) begin
      pkt_d     = {dy[7:0], dx[7:0], 2'b00, dy[8], dx[8], 1'b1, btn};
      pkt_cnt_d = 2'd3;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!clk_s2_q) state_d = ST_INHIBIT;
        else if (pend) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (!clk_s2_q) begin
          state_d = ST_INHIBIT;
          cnt_d   = '0;
        end else if (cnt_q == GAP_END) begin
          // Queued responses always go ahead of movement data.
          tx_byte  = (rq_cnt_q != '0) ? rq_mem_q[rq_rd_q] : pkt_q[7:0];
          tx_src_d = (rq_cnt_q == '0);
          frame_d  = {1'b1, ~^tx_byte, tx_byte, 1'b0};
          bit_d    = 4'd0;
          cnt_d    = '0;
          state_d  = ST_TX_HI;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_TX_HI: begin
        if (cnt_q == HALF_END) begin
          cnt_d = '0;
          // Host holding clock low before the stop bit: abandon, byte stays pending.
          if (!clk_s2_q && bit_q != 4'd10) state_d = ST_INHIBIT;
          else state_d = ST_TX_LO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_TX_LO: begin
        if (cnt_q == HALF_END) begin
          cnt_d = '0;
          if (bit_q == 4'd10) begin
            state_d = ST_IDLE;
            if (tx_src_q) begin
              pkt_d     = {8'h00, pkt_q[23:8]};
              pkt_cnt_d = pkt_cnt_q - 2'd1;
            end else begin
              rq_rd_d  = rq_rd_q + RQ_AW'(1);
              rq_cnt_d = rq_cnt_q - RQ_CW'(1);
            end
          end else begin
            bit_d   = bit_q + 4'd1;
            frame_d = {1'b1, frame_q[10:1]};
            state_d = ST_TX_HI;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_INHIBIT: begin
        if (!clk_s2_q) begin
          cnt_d = '0;
        end else if (cnt_q == HALF_END) begin
          cnt_d = '0;
          bit_d = 4'd0;
          // Data held low once the clock is released is a request-to-send.
          state_d = !dat_s2_q ? ST_RX_LO : ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RX_LO: begin
        if (cnt_q == HALF_END) begin
          cnt_d   = '0;
          state_d = ST_RX_HI;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RX_HI: begin
        if (cnt_q == HALF_END) begin
          cnt_d = '0;
          rx_d  = rx_word[9:1];
          if (bit_q == 4'd9) begin
            // rx_word = {stop, parity, data[7:0]}
            state_d   = ST_RX_ACK;
            pkt_d     = 24'h0;
            pkt_cnt_d = 2'd0;
            push_n    = 2'd1;
            if (^rx_word[8:0]) begin
              cmd_strobe_d = 1'b1;
              cmd_byte_d   = rx_word[7:0];
              push_b[0]    = 8'hFA;
              if (arg_q) begin
                arg_d = 1'b0;
              end else begin
                case (rx_word[7:0])
                  8'hFF: begin
                    push_n      = 2'd3;
                    push_b[1]   = 8'hAA;
                    push_b[2]   = 8'h00;
                    reporting_d = 1'b0;
                  end
                  8'hF2: begin
                    push_n    = 2'd2;
                    push_b[1] = 8'h00;
                  end
                  8'hF3: arg_d = 1'b1;
                  8'hF4: reporting_d = 1'b1;
                  8'hF5: reporting_d = 1'b0;
                  default: ;
                endcase
              end
            end else begin
              push_b[0] = 8'hFE;
            end
          end else begin
            bit_d   = bit_q + 4'd1;
            state_d = ST_RX_LO;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RX_ACK: begin
        if (cnt_q == ACK_END) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pushes only happen on RX completion, never in the same cycle as a pop.
    for (int i = 0; i < 3; i++) begin
      if (push_n > 2'(i) && rq_cnt_d != RQ_FULL) begin
        rq_mem_d[rq_wr_d] = push_b[i];
        rq_wr_d           = rq_wr_d + RQ_AW'(1);
        rq_cnt_d          = rq_cnt_d + RQ_CW'(1);
      end
    end

    // Line drivers are registered from the next state so they never glitch.
    clk_low_d = (state_d == ST_TX_LO) || (state_d == ST_RX_LO) ||
                ((state_d == ST_RX_ACK) && (cnt_d < HALF_LEN));
    dat_low_d = (((state_d == ST_TX_HI) || (state_d == ST_TX_LO)) && !frame_d[0]) ||
                (state_d == ST_RX_ACK);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_q        <= 4'd0;
      frame_q      <= 11'h7FF;
      rx_q         <= 9'h0;
      tx_src_q     <= 1'b0;
      pkt_q        <= 24'h0;
      pkt_cnt_q    <= 2'd0;
      for (int i = 0; i < RQ_DEPTH; i++) rq_mem_q[i] <= (i == 0) ? 8'hAA : 8'h00;
      rq_rd_q      <= '0;
      rq_wr_q      <= RQ_AW'(2);
      rq_cnt_q     <= RQ_CW'(2);
      reporting_q  <= 1'b0;
      cmd_byte_q   <= 8'h00;
      cmd_strobe_q <= 1'b0;
      arg_q        <= 1'b0;
      clk_low_q    <= 1'b0;
      dat_low_q    <= 1'b0;
      clk_s1_q     <= 1'b1;
      clk_s2_q     <= 1'b1;
      dat_s1_q     <= 1'b1;
      dat_s2_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      frame_q      <= frame_d;
      rx_q         <= rx_d;
      tx_src_q     <= tx_src_d;
      pkt_q        <= pkt_d;
      pkt_cnt_q    <= pkt_cnt_d;
      rq_mem_q     <= rq_mem_d;
      rq_rd_q      <= rq_rd_d;
      rq_wr_q      <= rq_wr_d;
      rq_cnt_q     <= rq_cnt_d;
      reporting_q  <= reporting_d;
      cmd_byte_q   <= cmd_byte_d;
      cmd_strobe_q <= cmd_strobe_d;
      arg_q        <= arg_d;
      clk_low_q    <= clk_low_d;
      dat_low_q    <= dat_low_d;
      clk_s1_q     <= ps2mclk;
      clk_s2_q     <= clk_s1_q;
      dat_s1_q     <= ps2mdat;
      dat_s2_q     <= dat_s1_q;
    end
  end

endmodule
